mitll_jtl_pipe: RTL and testbench

- Clocked, parametrised, multi-channel behavioural model of a chain of MITLL JTL stages, for use in cycle-based system simulation alongside the single-stage TimEx cell models.
- Each channel carries SFQ pulses, encoded as one-cycle-high strobes, through STAGES stages of STAGE_DELAY cycles each.
- Each channel enforces a minimum pulse-separation (holdoff) rule, drops violating pulses, flags a sticky per-channel error, and counts delivered pulses.

---
 rtl/mitll_jtl_pkg.sv | 29 ++
 rtl/mitll_jtl_lane.sv | 92 +++++++++
 rtl/mitll_jtl_pipe.sv | 50 +++++
 tb/tb_mitll_jtl_pipe.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mitll_jtl_pkg.sv
// Shared constants and helpers for the clocked MITLL JTL chain model.
// Latency, counter saturation and parameter legality live here so lane and top agree.
package mitll_jtl_pkg;

    // Total cycles from acceptance edge to the edge that raises out.
    function automatic int jtl_latency(input int stages, input int stage_delay);
        return stages * stage_delay;
    endfunction

    function automatic logic [63:0] cnt_sat(input int width);
        if (width >= 64) begin
            return '1;
        end
        return (64'd1 << width) - 64'd1;
    endfunction

    // A disabled holdoff (0) still gets a 1-bit counter that simply never loads nonzero.
    function automatic int holdoff_width(input int holdoff);
        if (holdoff < 1) begin
            return 1;
        end
        return $clog2(holdoff + 1);
    endfunction

    function automatic bit params_legal(input int channels, input int stages, input int stage_delay);
        return (channels > 0) && (stages > 0) && (stage_delay > 0);
    endfunction

endpackage

// File: rtl/mitll_jtl_lane.sv
// One pulse lane: holdoff gate, L-cycle delay line, sticky error and saturating counter.
module mitll_jtl_lane
    import mitll_jtl_pkg::*;
#(
    parameter int STAGES      = 3,
    parameter int STAGE_DELAY = 2,
    parameter int HOLDOFF     = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_pulse,
    input  logic             i_err_clr,
    output logic             o_out,
    output logic             o_err,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_busy
);

    localparam int L  = jtl_latency(STAGES, STAGE_DELAY);
    localparam int HW = holdoff_width(HOLDOFF);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cnt_sat(CNT_W));
    localparam logic [HW-1:0]    HOLD_LD  = HW'(HOLDOFF);

    logic [HW-1:0]    r_hold;
    logic [L-1:0]     r_dly;
    logic             r_out;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic             w_pulse;
    logic             w_accept;
    logic             w_viol;
    logic [L-1:0]     w_dly_next;

    assign w_pulse  = i_en & i_pulse;
    assign w_accept = w_pulse & (r_hold == '0);
    assign w_viol   = w_pulse & (r_hold != '0);

    // r_dly[0] captures the acceptance edge; the out register adds the final cycle.
    if (L == 1) begin : g_dly_one
        assign w_dly_next = w_accept;
    end else begin : g_dly_many
        assign w_dly_next = {r_dly[L-2:0], w_accept};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (w_accept) begin
            r_hold <= HOLD_LD;
        end else if (r_hold != '0) begin
            r_hold <= r_hold - HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly <= '0;
            r_out <= 1'b0;
        end else begin
            r_dly <= w_dly_next;
            r_out <= r_dly[L-1];
        end
    end

    // A violation on the same edge as a clear leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_viol) begin
            r_err <= 1'b1;
        end else if (i_err_clr) begin
            r_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_dly[L-1] && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_out  = r_out;
    assign o_err  = r_err;
    assign o_cnt  = r_cnt;
    assign o_busy = (|r_dly) | r_out;

endmodule

// File: rtl/mitll_jtl_pipe.sv
// Multi-channel clocked JTL chain: CHANNELS independent lanes sharing enable and error clear.
// busy is the OR of every lane's in-flight state.
module mitll_jtl_pipe
    import mitll_jtl_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int STAGES      = 3,
    parameter int STAGE_DELAY = 2,
    parameter int HOLDOFF     = 1,
    parameter int CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [CHANNELS-1:0]       in,
    input  logic                      err_clr,
    output logic [CHANNELS-1:0]       out,
    output logic [CHANNELS-1:0]       err,
    output logic [CHANNELS*CNT_W-1:0] pulse_cnt,
    output logic                      busy
);

    if (!params_legal(CHANNELS, STAGES, STAGE_DELAY)) begin : g_param_err
        $error("mitll_jtl_pipe: CHANNELS, STAGES and STAGE_DELAY must all be >= 1");
    end

    logic [CHANNELS-1:0] w_lane_busy;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
        mitll_jtl_lane #(
            .STAGES      (STAGES),
            .STAGE_DELAY (STAGE_DELAY),
            .HOLDOFF     (HOLDOFF),
            .CNT_W       (CNT_W)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_en      (en),
            .i_pulse   (in[gi]),
            .i_err_clr (err_clr),
            .o_out     (out[gi]),
            .o_err     (err[gi]),
            .o_cnt     (pulse_cnt[gi*CNT_W +: CNT_W]),
            .o_busy    (w_lane_busy[gi])
        );
    end

    assign busy = |w_lane_busy;

endmodule

// File: tb/tb_mitll_jtl_pipe.sv
// Directed bench for mitll_jtl_pipe: a default instance plus a CNT_W=2 instance on shared stimulus.
module tb_mitll_jtl_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        err_clr = 1'b0;
    logic [3:0]  in_v = 4'b0;

    logic [3:0]  out_v, err_v;
    logic [31:0] cnt_v;
    logic        busy_v;
    logic [3:0]  out_c2, err_c2;
    logic [7:0]  cnt_c2;
    logic        busy_c2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mitll_jtl_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in(in_v), .err_clr(err_clr),
        .out(out_v), .err(err_v), .pulse_cnt(cnt_v), .busy(busy_v)
    );

    mitll_jtl_pipe #(.CNT_W(2)) u_dut_c2 (
        .clk(clk), .rst_n(rst_n), .en(en), .in(in_v), .err_clr(err_clr),
        .out(out_c2), .err(err_c2), .pulse_cnt(cnt_c2), .busy(busy_c2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        in_v    = 4'b0;
        en      = 1'b1;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic cyc_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single pulse, latency and busy window
        do_reset();
        chk("rst_out",  64'(out_v),  64'h0);
        chk("rst_err",  64'(err_v),  64'h0);
        chk("rst_busy", 64'(busy_v), 64'h0);
        chk("rst_cnt",  64'(cnt_v),  64'h0);
        for (int c = 1; c <= 20; c++) begin
            in_v = (c == 10) ? 4'b0001 : 4'b0000;
            cyc_edge();
            in_v = 4'b0;
            chk($sformatf("s1_out@%0d", c), 64'(out_v), (c == 16) ? 64'h1 : 64'h0);
            if (c >= 11)
                chk($sformatf("s1_busy@%0d", c), 64'(busy_v), (c <= 16) ? 64'h1 : 64'h0);
            else if (c < 10)
                chk($sformatf("s1_busy@%0d", c), 64'(busy_v), 64'h0);
        end
        chk("s1_err", 64'(err_v), 64'h0);
        chk("s1_cnt", 64'(cnt_v), 64'h1);
        $display("scenario single_pulse done: total=%0d", total);

        // Holdoff violation and spaced pulses on lane 1
        do_reset();
        for (int c = 1; c <= 32; c++) begin
            in_v = (c == 5 || c == 6 || c == 20 || c == 22) ? 4'b0010 : 4'b0000;
            cyc_edge();
            in_v = 4'b0;
            chk($sformatf("s2_out@%0d", c), 64'(out_v),
                (c == 11 || c == 26 || c == 28) ? 64'h2 : 64'h0);
            chk($sformatf("s2_err@%0d", c), 64'(err_v), (c >= 6) ? 64'h2 : 64'h0);
        end
        chk("s2_cnt", 64'(cnt_v), 64'h0000_0300);
        $display("scenario holdoff done: total=%0d", total);

        // Enable gating, then all lanes together
        do_reset();
        for (int c = 1; c <= 18; c++) begin
            en   = (c == 3) ? 1'b0 : 1'b1;
            in_v = (c == 3 || c == 8) ? 4'hF : 4'h0;
            cyc_edge();
            en   = 1'b1;
            in_v = 4'b0;
            chk($sformatf("s3_out@%0d", c), 64'(out_v), (c == 14) ? 64'hF : 64'h0);
            chk($sformatf("s3_err@%0d", c), 64'(err_v), 64'h0);
            if (c <= 7)
                chk($sformatf("s3_busy@%0d", c), 64'(busy_v), 64'h0);
        end
        chk("s3_cnt", 64'(cnt_v), 64'h0101_0101);
        $display("scenario enable_all_lanes done: total=%0d", total);

        // Counter saturation: lane 2, five pulses three cycles apart
        do_reset();
        for (int c = 1; c <= 24; c++) begin
            in_v = (c == 2 || c == 5 || c == 8 || c == 11 || c == 14) ? 4'b0100 : 4'b0000;
            cyc_edge();
            in_v = 4'b0;
            chk($sformatf("s4_out@%0d", c), 64'(out_c2),
                (c == 8 || c == 11 || c == 14 || c == 17 || c == 20) ? 64'h4 : 64'h0);
            if (c == 8)
                chk("s4_c2_first", 64'(cnt_c2), 64'h10);
            if (c == 17) begin
                chk("s4_c2_sat17", 64'(cnt_c2), 64'h30);
                chk("s4_c8_17", 64'(cnt_v[23:16]), 64'h4);
            end
        end
        chk("s4_c2_final", 64'(cnt_c2), 64'h30);
        chk("s4_c8_final", 64'(cnt_v), 64'h0005_0000);
        $display("scenario saturation done: total=%0d", total);

        // err_clr racing a new violation, then clearing alone
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            in_v    = (c == 2 || c == 3 || c == 5 || c == 6) ? 4'b0010 : 4'b0000;
            err_clr = (c == 6 || c == 7);
            cyc_edge();
            in_v    = 4'b0;
            err_clr = 1'b0;
            chk($sformatf("s5_err@%0d", c), 64'(err_v),
                (c >= 3 && c <= 6) ? 64'h2 : 64'h0);
            if (c == 8)
                chk("s5_out8", 64'(out_v), 64'h2);
        end
        $display("scenario err_clr done: total=%0d", total);

        // Asynchronous reset mid-flight
        do_reset();
        for (int c = 1; c <= 24; c++) begin
            in_v = (c == 10 || c == 15) ? 4'b0001 : 4'b0000;
            cyc_edge();
            in_v = 4'b0;
            if (c == 14)
                rst_n = 1'b1;
            chk($sformatf("s6_out@%0d", c), 64'(out_v), (c == 21) ? 64'h1 : 64'h0);
            if (c == 12) begin
                chk("s6_busy_pre", 64'(busy_v), 64'h1);
                #4;
                rst_n = 1'b0;
                #1;
                chk("s6_rst_out",  64'(out_v),  64'h0);
                chk("s6_rst_busy", 64'(busy_v), 64'h0);
                chk("s6_rst_err",  64'(err_v),  64'h0);
                chk("s6_rst_cnt",  64'(cnt_v),  64'h0);
            end
            if (c == 14)
                chk("s6_busy_rel", 64'(busy_v), 64'h0);
            if (c == 15)
                chk("s6_busy_new", 64'(busy_v), 64'h1);
        end
        chk("s6_cnt", 64'(cnt_v), 64'h1);
        $display("scenario reset_midflight done: total=%0d", total);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
